muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit. It sits beside the single-cycle ALU in the execute stage.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM states and operand-sign helpers.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIN
   } state_e;

   function automatic logic is_div(input logic [2:0] op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(input logic [2:0] op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic is_mul_high(input logic [2:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction

   function automatic logic a_signed(input logic [2:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic b_signed(input logic [2:0] op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle on operand magnitudes,
// sign fixed up in a final cycle. Start/busy/done handshake toward the control FSM.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           st_q, st_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    count_q, count_d;
   logic             neg_q, neg_d;
   logic             special_q, special_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;

   // Operand signs and magnitudes; MIN maps onto itself as an unsigned 2^(WIDTH-1).
   logic             sa, sb;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign sa    = a_signed(op) & operand_a[WIDTH-1];
   assign sb    = b_signed(op) & operand_b[WIDTH-1];
   assign a_mag = sa ? -operand_a : operand_a;
   assign b_mag = sb ? -operand_b : operand_b;

   // Shared adder: hi + multiplicand for mul, {rem, next dividend bit} - divisor for div.
   logic [WIDTH:0] add_a, add_b, add_sum;
   logic           add_cin;

   always_comb begin
      add_a   = {1'b0, hi_q};
      add_b   = '0;
      add_cin = 1'b0;
      if (is_div(op_q)) begin
         add_a   = {hi_q, lo_q[WIDTH-1]};
         add_b   = ~{1'b0, b_q};
         add_cin = 1'b1;
      end else if (lo_q[0]) begin
         add_b   = {1'b0, b_q};
      end
      add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
   end

   // Sign correction applied in FIN.
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   div_val, div_s, fin_val;

   assign prod    = {hi_q, lo_q};
   assign prod_s  = neg_q ? -prod : prod;
   assign div_val = is_rem(op_q) ? hi_q : lo_q;
   assign div_s   = neg_q ? -div_val : div_val;

   always_comb begin
      fin_val = prod_s[WIDTH-1:0];
      if (special_q) begin
         fin_val = hi_q;
      end else if (is_div(op_q)) begin
         fin_val = div_s;
      end else if (is_mul_high(op_q)) begin
         fin_val = prod_s[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      st_d      = st_q;
      op_d      = op_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      b_d       = b_q;
      count_d   = count_q;
      neg_d     = neg_q;
      special_d = special_q;
      done_d    = 1'b0;
      result_d  = result_q;

      unique case (st_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = op;
               neg_d   = is_rem(op) ? sa : (sa ^ sb);
               hi_d    = '0;
               count_d = CW'(WIDTH - 1);
               if (is_div(op) && operand_b == '0) begin
                  special_d = 1'b1;
                  hi_d      = is_rem(op) ? operand_a : '1;
                  st_d      = ST_FIN;
               end else if (a_signed(op) && is_div(op) && operand_a == MIN_VAL &&
                            operand_b == '1) begin
                  special_d = 1'b1;
                  hi_d      = is_rem(op) ? '0 : MIN_VAL;
                  st_d      = ST_FIN;
               end else begin
                  special_d = 1'b0;
                  // Div shifts the dividend out of lo; mul shifts the multiplier out of lo.
                  lo_d      = is_div(op) ? a_mag : b_mag;
                  b_d       = is_div(op) ? b_mag : a_mag;
                  st_d      = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (is_div(op_q)) begin
               if (!add_sum[WIDTH]) begin
                  hi_d = add_sum[WIDTH-1:0];
               end else begin
                  hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
               end
               lo_d = {lo_q[WIDTH-2:0], ~add_sum[WIDTH]};
            end else begin
               hi_d = add_sum[WIDTH:1];
               lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end
            if (count_q == '0) begin
               st_d = ST_FIN;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         ST_FIN: begin
            result_d = fin_val;
            done_d   = 1'b1;
            st_d     = ST_IDLE;
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st_q      <= ST_IDLE;
         op_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         st_q      <= st_d;
         op_q      <= op_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         b_q       <= b_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         special_q <= special_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (st_q != ST_IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results and latencies are queued at start
// and checked when done pulses; busy is checked every cycle an op is outstanding.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        busy, done;
   logic [31:0] result;

   muldiv_unit #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   int          lat_q[$];
   int          t0_q[$];
   string       tag_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
      end
   endtask

   task automatic flush();
      exp_q.delete();
      lat_q.delete();
      t0_q.delete();
      tag_q.delete();
   endtask

   // Called #1 after a posedge with the DUT idle; returns #1 after the next posedge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int lat, input string tag);
      op = o;
      operand_a = a;
      operand_b = b;
      start = 1'b1;
      exp_q.push_back(want);
      lat_q.push_back(lat);
      t0_q.push_back(cyc);
      tag_q.push_back(tag);
      @(posedge clock);
      #1;
      start = 1'b0;
      op = 3'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clock);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         check_eq({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
         flush();
      end
   endtask

   always @(negedge clock) begin
      int d;
      if (!reset) begin
         if (exp_q.size() != 0) begin
            d = cyc - t0_q[0];
            check_eq({tag_q[0], "_busy"}, {31'd0, busy}, (d >= 1 && d < lat_q[0]) ? 32'd1 : 32'd0);
            if (done) begin
               check_eq({tag_q[0], "_result"}, result, exp_q[0]);
               check_eq({tag_q[0], "_latency"}, 32'(d), 32'(lat_q[0]));
               void'(exp_q.pop_front());
               void'(lat_q.pop_front());
               void'(t0_q.pop_front());
               void'(tag_q.pop_front());
            end
         end else if (done) begin
            check_eq("spurious_done", {31'd0, done}, 32'd0);
         end
      end
   end

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (o)
         OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
         OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default:   return (b == 0) ? a : a % b;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      int n_done;
      logic [2:0]  o;
      logic [31:0] a, b;
      int          r;

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check_eq("reset_busy", {31'd0, busy}, 32'd0);
      check_eq("reset_done", {31'd0, done}, 32'd0);
      check_eq("reset_result", result, 32'd0);

      issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
      wait_idle("mul");
      issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
      wait_idle("mulh");
      issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
      wait_idle("mulhu");
      issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
      wait_idle("mulhsu");
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");
      wait_idle("div");
      issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");
      wait_idle("rem");
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu");
      wait_idle("divu");
      issue(OP_REMU, 32'd100, 32'd7, 32'd2, 34, "remu");
      wait_idle("remu");

      issue(OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0");
      wait_idle("divu_by0");
      issue(OP_REM, 32'h1234, 32'd0, 32'h1234, 2, "rem_by0");
      wait_idle("rem_by0");
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
      wait_idle("div_ovf");
      issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf");
      wait_idle("rem_ovf");

      // Abort a divide with reset in cycle 10.
      issue(OP_DIV, 32'h1234_5678, 32'd3, 32'd0, 34, "div_abort");
      repeat (9) @(posedge clock);
      #1;
      flush();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_done", {31'd0, done}, 32'd0);
      check_eq("abort_result", result, 32'd0);
      n_done = 0;
      repeat (40) begin
         @(negedge clock);
         if (done) n_done++;
      end
      check_eq("abort_no_done", 32'(n_done), 32'd0);
      @(posedge clock);
      #1;
      issue(OP_MUL, 32'd3, 32'd5, 32'd15, 34, "mul_after_abort");
      wait_idle("mul_after_abort");

      // Start while busy is ignored; a start in the done cycle is accepted.
      t0 = cyc;
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_ignore");
      repeat (3) @(posedge clock);
      #1;
      op = OP_MUL;
      operand_a = 32'd9;
      operand_b = 32'd9;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      while (cyc != t0 + 34) begin
         @(posedge clock);
         #1;
      end
      issue(OP_MUL, 32'h0001_2345, 32'h10, 32'h0012_3450, 34, "mul_b2b");
      wait_idle("mul_b2b");

      for (int i = 0; i < 16; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         r = $urandom_range(0, 5);
         if (r == 0) b = 32'd0;
         if (r == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         if (r == 2) b = 32'($urandom_range(1, 20));
         issue(o, a, b, model(o, a, b),
               (is_div(o) && (b == 0 || (b_signed(o) && a == 32'h8000_0000 &&
                b == 32'hFFFF_FFFF))) ? 2 : 34, "rand");
         wait_idle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
